hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It reads the register and control fields that the ID/EX register presents, together with the IF/ID, EX/MEM and MEM/WB fields.
- It generates the ID/EX flush (e_flush), the IF/ID and PC stall/flush controls, and the EX-stage operand-forwarding selects.
- It contains a load-use stall FSM with a stall-length counter, a memory-wait freeze, and saturating performance counters.

Parameters:
- LOAD_STALL_CYC, 1, number of bubble cycles inserted per load-use hazard (range 1..7).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
- ifid_rs1_used, ifid_rs2_used  in  1 each  the ID instruction reads rs1 / rs2.
- idex_rs1, idex_rs2  in  5 each  source registers held in ID/EX.
- idex_rd  in  5  destination register held in ID/EX.
- idex_rf_wr_en  in  1  ID/EX register-file write enable.
- idex_dm_rd_ctrl  in  3  ID/EX load control; nonzero means a load.
- exmem_rd, memwb_rd  in  5 each  destination registers in EX/MEM and MEM/WB.
- exmem_rf_wr_en, memwb_rf_wr_en  in  1 each  write enables in EX/MEM and MEM/WB.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- mem_wait  in  1  data memory not ready; the whole pipe must hold.
- cnt_clr  in  1  synchronous clear of the performance counters.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID.
- e_flush  out  1  zero ID/EX (bubble).
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (rstn=0, asynchronous): state=RUN, bubble counter=0, stall_cnt=0, flush_cnt=0. While rstn=0, all stall/flush/hold outputs are 0 and fwd_*_sel=00.
- Load-use detect (lu):
  - idex_dm_rd_ctrl!=0 AND idex_rf_wr_en AND idex_rd!=0, AND
  - (ifid_rs1_used AND ifid_rs1==idex_rd) OR (ifid_rs2_used AND ifid_rs2==idex_rd).
- FSM states: RUN, LU_STALL.
- Action priority each cycle: mem_wait > ex_redirect > lu.
  - mem_wait=1: pc_stall=ifid_stall=pipe_hold=1, all flushes 0. FSM state, bubble counter and perf counters hold. Applies in any state.
  - ex_redirect=1 (no mem_wait): ifid_flush=1, e_flush=1, pc_stall=0. flush_cnt increments (saturating). FSM goes to RUN and the counter clears, aborting any load-use stall.
  - RUN and lu: pc_stall=ifid_stall=1, e_flush=1, stall_cnt increments. If LOAD_STALL_CYC>1, go to LU_STALL with counter=LOAD_STALL_CYC-1; otherwise remain in RUN.
  - LU_STALL: pc_stall=ifid_stall=1, e_flush=1, stall_cnt increments, counter decrements. Return to RUN on the cycle the counter equals 1. Load-use detection is suppressed while in LU_STALL.
  - Otherwise all stall/flush/hold outputs are 0.
- Result: exactly LOAD_STALL_CYC bubbles per hazard absent mem_wait. mem_wait cycles extend the stall without adding bubbles.
- Forwarding is combinational and independent of the FSM. fwd_a_sel uses idex_rs1; fwd_b_sel uses idex_rs2.
  - 01 if exmem_rf_wr_en AND exmem_rd!=0 AND exmem_rd==rs.
  - Else 10 if memwb_rf_wr_en AND memwb_rd!=0 AND memwb_rd==rs.
  - Else 00. EX/MEM wins over MEM/WB when both match.
- Counters:
  - Saturate at all-ones.
  - cnt_clr zeroes both counters and has priority over an increment in the same cycle.
  - Counters hold during mem_wait.

Decomposition:
- Shared package hazard_pkg: FSM state encoding (RUN, LU_STALL), FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, LOAD_NONE=3'b000.
- One sub-module fwd_sel (rs, exmem_rd/en, memwb_rd/en -> 2-bit sel), instantiated for operands A and B.

Test Plan:
- lw x5 in ID/EX, add using x6,x5 in ID, LOAD_STALL_CYC=1 -> one cycle of pc_stall=ifid_stall=e_flush=1, then all 0. The following cycle has memwb_rd=5 and fwd_b_sel=10. stall_cnt=1.
- LOAD_STALL_CYC=3, same hazard with mem_wait=1 on the 2nd stall cycle -> e_flush is high for 3 non-wait cycles. pipe_hold=1 and e_flush=0 during the wait cycle. stall_cnt=3.
- ex_redirect=1 during cycle 1 of LU_STALL (LOAD_STALL_CYC=3) -> ifid_flush=e_flush=1, pc_stall=0. State returns to RUN. flush_cnt=1, and stall_cnt stops at 1.
- exmem_rd=7/en=1, memwb_rd=7/en=1, idex_rs1=7 -> fwd_a_sel=01. Repeat with exmem_rd=0 -> fwd_a_sel=10. Repeat with idex_rs1=0 and both rd=0 -> 00.
- Load to x0 with an x0 consumer in ID -> no stall. Load to x3 with a consumer whose ifid_rs1_used=0 and ifid_rs1=3 -> no stall.
- Preload stall_cnt near all-ones with CNT_W=4: 20 hazards -> stall_cnt=15. Then cnt_clr together with a hazard -> stall_cnt=0. Assert rstn=0 mid-LU_STALL -> all outputs 0 immediately and state RUN after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;
    typedef enum logic {RUN, LU_STALL} state_t;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [2:0] LOAD_NONE = 3'b000;
endpackage

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if: pipeline register fields into, and stall/flush/forward controls out of, the hazard unit.
interface hazard_fwd_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs1, ifid_rs2;
    logic             ifid_rs1_used, ifid_rs2_used;
    logic [4:0]       idex_rs1, idex_rs2, idex_rd;
    logic             idex_rf_wr_en;
    logic [2:0]       idex_dm_rd_ctrl;
    logic [4:0]       exmem_rd, memwb_rd;
    logic             exmem_rf_wr_en, memwb_rf_wr_en;
    logic             ex_redirect, mem_wait, cnt_clr;
    logic             pc_stall, ifid_stall, ifid_flush, e_flush, pipe_hold;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used, idex_rs1, idex_rs2, idex_rd,
               idex_rf_wr_en, idex_dm_rd_ctrl, exmem_rd, memwb_rd, exmem_rf_wr_en, memwb_rf_wr_en,
               ex_redirect, mem_wait, cnt_clr,
        input  pc_stall, ifid_stall, ifid_flush, e_flush, pipe_hold, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used, idex_rs1, idex_rs2, idex_rd,
               idex_rf_wr_en, idex_dm_rd_ctrl, exmem_rd, memwb_rd, exmem_rf_wr_en, memwb_rf_wr_en,
               ex_redirect, mem_wait, cnt_clr,
        output pc_stall, ifid_stall, ifid_flush, e_flush, pipe_hold, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// fwd_sel: picks the EX operand source; the younger EX/MEM result beats MEM/WB.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_en,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_en,
    output logic [1:0] sel
);
    assign sel = (exmem_en && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
                 (memwb_en && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall FSM, redirect flush, memory-wait freeze, EX forwarding and perf counters.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input logic              clk,
    input logic              rstn,
    hazard_fwd_unit_if.slave hz
);
    state_t           state, state_nxt;
    logic [2:0]       bub, bub_nxt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             lu, stall_ev, flush_ev;
    logic             pc_stall, ifid_stall, ifid_flush, e_flush, pipe_hold;
    logic [1:0]       fwd_a, fwd_b;

    assign lu = hz.idex_dm_rd_ctrl != LOAD_NONE && hz.idex_rf_wr_en && hz.idex_rd != '0 &&
                ((hz.ifid_rs1_used && hz.ifid_rs1 == hz.idex_rd) ||
                 (hz.ifid_rs2_used && hz.ifid_rs2 == hz.idex_rd));

    always_comb begin
        state_nxt  = state;
        bub_nxt    = bub;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        e_flush    = 1'b0;
        pipe_hold  = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        if (hz.mem_wait) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            pipe_hold  = 1'b1;
        end else if (hz.ex_redirect) begin
            ifid_flush = 1'b1;
            e_flush    = 1'b1;
            flush_ev   = 1'b1;
            state_nxt  = RUN;
            bub_nxt    = '0;
        end else if (state == LU_STALL) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            e_flush    = 1'b1;
            stall_ev   = 1'b1;
            bub_nxt    = bub - 3'd1;
            state_nxt  = (bub == 3'd1) ? RUN : LU_STALL;
        end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            e_flush    = 1'b1;
            stall_ev   = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
                state_nxt = LU_STALL;
                bub_nxt   = 3'(LOAD_STALL_CYC - 1);
            end
        end
    end

    // Counters saturate at all-ones; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            bub       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            bub       <= bub_nxt;
            stall_cnt <= hz.cnt_clr ? '0 : (stall_ev && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= hz.cnt_clr ? '0 : (flush_ev && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end

    fwd_sel u_fwd_a (.rs(hz.idex_rs1), .exmem_rd(hz.exmem_rd), .exmem_en(hz.exmem_rf_wr_en),
                     .memwb_rd(hz.memwb_rd), .memwb_en(hz.memwb_rf_wr_en), .sel(fwd_a));
    fwd_sel u_fwd_b (.rs(hz.idex_rs2), .exmem_rd(hz.exmem_rd), .exmem_en(hz.exmem_rf_wr_en),
                     .memwb_rd(hz.memwb_rd), .memwb_en(hz.memwb_rf_wr_en), .sel(fwd_b));

    // Controls are forced quiet for the whole time reset is held, not just from the next edge.
    assign hz.pc_stall   = rstn && pc_stall;
    assign hz.ifid_stall = rstn && ifid_stall;
    assign hz.ifid_flush = rstn && ifid_flush;
    assign hz.e_flush    = rstn && e_flush;
    assign hz.pipe_hold  = rstn && pipe_hold;
    assign hz.fwd_a_sel  = rstn ? fwd_a : FWD_RF;
    assign hz.fwd_b_sel  = rstn ? fwd_b : FWD_RF;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scoreboard bench for two hazard_fwd_unit builds (1-cycle/4-bit and 3-cycle/16-bit).
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [8:0] sb[$];
    logic [8:0] exp;

    // Expected vector: {pc_stall, ifid_stall, ifid_flush, e_flush, pipe_hold, fwd_a_sel, fwd_b_sel}
    localparam logic [8:0] NONE  = 9'b00000_00_00;
    localparam logic [8:0] STALL = 9'b11010_00_00;
    localparam logic [8:0] REDIR = 9'b00110_00_00;
    localparam logic [8:0] HOLD  = 9'b11001_00_00;

    hazard_fwd_unit_if #(.CNT_W(4))  ia ();
    hazard_fwd_unit_if #(.CNT_W(16)) ib ();

    hazard_fwd_unit #(.LOAD_STALL_CYC(1), .CNT_W(4))  ua (.clk(clk), .rstn(rstn), .hz(ia));
    hazard_fwd_unit #(.LOAD_STALL_CYC(3), .CNT_W(16)) ub (.clk(clk), .rstn(rstn), .hz(ib));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] oa();
        return {ia.pc_stall, ia.ifid_stall, ia.ifid_flush, ia.e_flush, ia.pipe_hold, ia.fwd_a_sel, ia.fwd_b_sel};
    endfunction

    function automatic logic [8:0] ob();
        return {ib.pc_stall, ib.ifid_stall, ib.ifid_flush, ib.e_flush, ib.pipe_hold, ib.fwd_a_sel, ib.fwd_b_sel};
    endfunction

    task automatic idle();
        {ia.ifid_rs1, ia.ifid_rs2, ia.ifid_rs1_used, ia.ifid_rs2_used, ia.idex_rs1, ia.idex_rs2, ia.idex_rd,
         ia.idex_rf_wr_en, ia.idex_dm_rd_ctrl, ia.exmem_rd, ia.memwb_rd, ia.exmem_rf_wr_en, ia.memwb_rf_wr_en,
         ia.ex_redirect, ia.mem_wait, ia.cnt_clr} = '0;
        {ib.ifid_rs1, ib.ifid_rs2, ib.ifid_rs1_used, ib.ifid_rs2_used, ib.idex_rs1, ib.idex_rs2, ib.idex_rd,
         ib.idex_rf_wr_en, ib.idex_dm_rd_ctrl, ib.exmem_rd, ib.memwb_rd, ib.exmem_rf_wr_en, ib.memwb_rf_wr_en,
         ib.ex_redirect, ib.mem_wait, ib.cnt_clr} = '0;
    endtask

    task automatic haz_a(input logic [4:0] rd, r1, r2, input logic u1, u2);
        ia.idex_dm_rd_ctrl = 3'b010;
        ia.idex_rf_wr_en   = 1'b1;
        ia.idex_rd         = rd;
        ia.ifid_rs1        = r1;
        ia.ifid_rs2        = r2;
        ia.ifid_rs1_used   = u1;
        ia.ifid_rs2_used   = u2;
    endtask

    task automatic haz_b(input logic [4:0] rd, r1, r2, input logic u1, u2);
        ib.idex_dm_rd_ctrl = 3'b010;
        ib.idex_rf_wr_en   = 1'b1;
        ib.idex_rd         = rd;
        ib.ifid_rs1        = r1;
        ib.ifid_rs2        = r2;
        ib.ifid_rs1_used   = u1;
        ib.ifid_rs2_used   = u2;
    endtask

    task automatic test_reset();
        idle();
        ia.mem_wait = 1'b1; ia.exmem_rd = 5'd7; ia.exmem_rf_wr_en = 1'b1; ia.idex_rs1 = 5'd7;
        ib.ex_redirect = 1'b1; ib.memwb_rd = 5'd4; ib.memwb_rf_wr_en = 1'b1; ib.idex_rs2 = 5'd4;
        #2;
        checks++;
        if (oa() !== NONE) begin failures++; $display("FAIL reset_outs_a got=%b exp=%b", oa(), NONE); end
        checks++;
        if (ob() !== NONE) begin failures++; $display("FAIL reset_outs_b got=%b exp=%b", ob(), NONE); end
        checks++;
        if ({ia.stall_cnt, ia.flush_cnt, ib.stall_cnt, ib.flush_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_cnts got=%h/%h/%h/%h exp=0", ia.stall_cnt, ia.flush_cnt, ib.stall_cnt, ib.flush_cnt);
        end
        idle();
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_load_use_1();
        @(posedge clk); #1 idle(); haz_a(5'd5, 5'd6, 5'd5, 1'b1, 1'b1); sb.push_back(STALL);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL lu1_stall got=%b exp=%b", oa(), exp); end
        @(posedge clk); #1 idle();
        ia.exmem_rd = 5'd5; ia.exmem_rf_wr_en = 1'b1;
        ia.ifid_rs1 = 5'd6; ia.ifid_rs2 = 5'd5; ia.ifid_rs1_used = 1'b1; ia.ifid_rs2_used = 1'b1;
        sb.push_back(NONE);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL lu1_release got=%b exp=%b", oa(), exp); end
        @(posedge clk); #1 idle();
        ia.memwb_rd = 5'd5; ia.memwb_rf_wr_en = 1'b1;
        ia.idex_rs1 = 5'd6; ia.idex_rs2 = 5'd5; ia.idex_rd = 5'd7; ia.idex_rf_wr_en = 1'b1;
        sb.push_back(9'b00000_00_10);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL lu1_fwd got=%b exp=%b", oa(), exp); end
        @(posedge clk); #1 idle(); checks++;
        if (ia.stall_cnt !== 4'd1) begin failures++; $display("FAIL lu1_cnt got=%0d exp=1", ia.stall_cnt); end
    endtask

    task automatic test_lu3_wait();
        logic       mw[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       hz[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [8:0] ex[5] = '{STALL, HOLD, STALL, STALL, NONE};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 idle();
            if (hz[i]) haz_b(5'd5, 5'd6, 5'd5, 1'b1, 1'b1);
            ib.mem_wait = mw[i];
            sb.push_back(ex[i]);
            @(negedge clk) exp = sb.pop_front(); checks++;
            if (ob() !== exp) begin failures++; $display("FAIL lu3_wait c%0d got=%b exp=%b", i, ob(), exp); end
        end
        @(posedge clk); #1 idle(); checks++;
        if (ib.stall_cnt !== 16'd3 || ib.flush_cnt !== 16'd0) begin
            failures++; $display("FAIL lu3_cnt got=%0d/%0d exp=3/0", ib.stall_cnt, ib.flush_cnt);
        end
    endtask

    task automatic test_redirect();
        @(posedge clk); #1 idle(); ib.cnt_clr = 1'b1; sb.push_back(NONE);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (ob() !== exp) begin failures++; $display("FAIL redir_clr got=%b exp=%b", ob(), exp); end
        @(posedge clk); #1 idle(); haz_b(5'd9, 5'd9, 5'd0, 1'b1, 1'b0); sb.push_back(STALL);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (ob() !== exp) begin failures++; $display("FAIL redir_stall got=%b exp=%b", ob(), exp); end
        @(posedge clk); #1 idle(); ib.ex_redirect = 1'b1; sb.push_back(REDIR);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (ob() !== exp) begin failures++; $display("FAIL redir_flush got=%b exp=%b", ob(), exp); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 idle(); sb.push_back(NONE);
            @(negedge clk) exp = sb.pop_front(); checks++;
            if (ob() !== exp) begin failures++; $display("FAIL redir_after c%0d got=%b exp=%b", i, ob(), exp); end
        end
        checks++;
        if (ib.stall_cnt !== 16'd1 || ib.flush_cnt !== 16'd1) begin
            failures++; $display("FAIL redir_cnt got=%0d/%0d exp=1/1", ib.stall_cnt, ib.flush_cnt);
        end
    endtask

    task automatic test_forwarding();
        // {rs1, rs2, ex_rd, ex_en, wb_rd, wb_en, sel_a, sel_b}
        logic [25:0] tab[6] = '{
            {5'd7, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 2'b01, 2'b00},
            {5'd7, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 2'b10, 2'b10},
            {5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00},
            {5'd9, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 2'b10, 2'b10},
            {5'd3, 5'd4, 5'd3, 1'b1, 5'd4, 1'b1, 2'b01, 2'b10},
            {5'd4, 5'd3, 5'd3, 1'b1, 5'd4, 1'b0, 2'b00, 2'b01}};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 idle();
            {ia.idex_rs1, ia.idex_rs2, ia.exmem_rd, ia.exmem_rf_wr_en, ia.memwb_rd, ia.memwb_rf_wr_en} = tab[i][25:4];
            sb.push_back({5'b0, tab[i][3:0]});
            @(negedge clk) exp = sb.pop_front(); checks++;
            if (oa() !== exp) begin failures++; $display("FAIL fwd c%0d got=%b exp=%b", i, oa(), exp); end
        end
    endtask

    task automatic test_no_hazard();
        @(posedge clk); #1 idle(); haz_a(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); sb.push_back(NONE);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", oa(), exp); end
        @(posedge clk); #1 idle(); haz_a(5'd3, 5'd3, 5'd4, 1'b0, 1'b1); sb.push_back(NONE);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL lu_unused got=%b exp=%b", oa(), exp); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 idle(); haz_a(5'd2, 5'd2, 5'd0, 1'b1, 1'b0); sb.push_back(STALL);
            @(negedge clk) exp = sb.pop_front(); checks++;
            if (oa() !== exp) begin failures++; $display("FAIL sat_stall c%0d got=%b exp=%b", i, oa(), exp); end
        end
        @(posedge clk); #1 checks++;
        if (ia.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", ia.stall_cnt); end
        ia.cnt_clr = 1'b1; sb.push_back(STALL);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (oa() !== exp) begin failures++; $display("FAIL clr_stall got=%b exp=%b", oa(), exp); end
        @(posedge clk); #1 idle(); checks++;
        if (ia.stall_cnt !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", ia.stall_cnt); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 idle(); haz_b(5'd8, 5'd0, 5'd8, 1'b0, 1'b1); sb.push_back(STALL);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (ob() !== exp) begin failures++; $display("FAIL rmid_c0 got=%b exp=%b", ob(), exp); end
        @(posedge clk); #1 idle(); ib.exmem_rd = 5'd1; ib.exmem_rf_wr_en = 1'b1; ib.idex_rs1 = 5'd1;
        sb.push_back(9'b11010_01_00);
        @(negedge clk) exp = sb.pop_front(); checks++;
        if (ob() !== exp) begin failures++; $display("FAIL rmid_c1 got=%b exp=%b", ob(), exp); end
        #1 rstn = 1'b0;
        #1 checks++;
        if (ob() !== NONE) begin failures++; $display("FAIL rmid_async got=%b exp=%b", ob(), NONE); end
        checks++;
        if (ib.stall_cnt !== 16'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", ib.stall_cnt); end
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 idle(); sb.push_back(NONE);
            @(negedge clk) exp = sb.pop_front(); checks++;
            if (ob() !== exp) begin failures++; $display("FAIL rmid_run c%0d got=%b exp=%b", i, ob(), exp); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use_1();
        test_lu3_wait();
        test_redirect();
        test_forwarding();
        test_no_hazard();
        test_saturate();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
